// File: rtl/ufm_led_sequencer.sv
// rtl/ufm_led_sequencer.sv - plays an LED blink sequence fetched word-by-word from UFM
//
// Each UFM step word is {duration[15:8], pattern[7:0]}. The pattern is shown on
// led for duration*TICK_DIV clocks. A zero duration ends the sequence.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           begin playback (sampled only in IDLE)
//   ufm_addr        UFM word address
//   ufm_nread       active-low single-cycle read strobe
//   ufm_busy        UFM busy; strobe is only issued while low
//   ufm_data_valid  ufm_data valid this cycle
//   ufm_data        UFM read data
//   led             LED pattern
//   running         high from leaving IDLE until DONE
//   done            one-cycle end-of-sequence pulse
//   error           sticky read-timeout flag
module ufm_led_sequencer #(
  parameter int ADDR_W    = 9,
  parameter int BASE_ADDR = 0,
  parameter int N_STEPS   = 16,
  parameter int TICK_DIV  = 1000,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ufm_addr,
  output logic              ufm_nread,
  input  logic              ufm_busy,
  input  logic              ufm_data_valid,
  input  logic [15:0]       ufm_data,
  output logic [7:0]        led,
  output logic              running,
  output logic              done,
  output logic              error
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int STEP_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SHOW, S_DONE} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                nread_d;
  logic [7:0]          led_d;
  logic                running_d, done_d, error_d;
  logic [PRE_W-1:0]    pre, pre_d;
  logic [STEP_W-1:0]   step, step_d;
  logic [7:0]          dur, dur_d;
  logic [TO_W-1:0]     tcnt, tcnt_d;

  logic [TO_W-1:0]     tcnt_inc;
  logic                tick, last_tick, last_step, timeout_hit, end_marker;

  assign tcnt_inc    = tcnt + 1'b1;
  assign tick        = (pre == PRE_W'(TICK_DIV - 1));
  // dur is never 0 inside SHOW, so the tick that takes it from 1 ends the step
  assign last_tick   = tick && (dur == 8'd1);
  assign last_step   = (step == STEP_W'(N_STEPS - 1));
  // WAIT lasts at most TIMEOUT cycles counting the strobe cycle
  assign timeout_hit = (tcnt_inc == TO_W'(TIMEOUT));
  assign end_marker  = (ufm_data[15:8] == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ufm_addr  <= ADDR_W'(BASE_ADDR);
      ufm_nread <= 1'b1;
      led       <= 8'd0;
      running   <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      pre       <= '0;
      step      <= '0;
      dur       <= 8'd0;
      tcnt      <= '0;
    end else begin
      state     <= state_d;
      ufm_addr  <= addr_d;
      ufm_nread <= nread_d;
      led       <= led_d;
      running   <= running_d;
      done      <= done_d;
      error     <= error_d;
      pre       <= pre_d;
      step      <= step_d;
      dur       <= dur_d;
      tcnt      <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ:  if (!ufm_busy) state_d = S_WAIT;
      S_WAIT: begin
        // valid takes priority over a coincident timeout
        if (ufm_data_valid) state_d = end_marker ? S_DONE : S_SHOW;
        else if (timeout_hit) state_d = S_DONE;
      end
      S_SHOW: if (last_tick) state_d = last_step ? S_DONE : S_REQ;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d    = ufm_addr;
    nread_d   = 1'b1;
    led_d     = led;
    running_d = running;
    done_d    = 1'b0;
    error_d   = error;
    pre_d     = pre;
    step_d    = step;
    dur_d     = dur;
    tcnt_d    = tcnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          addr_d    = ADDR_W'(BASE_ADDR);
          step_d    = '0;
          error_d   = 1'b0;
          running_d = 1'b1;
        end
      end
      S_REQ: begin
        if (!ufm_busy) begin
          nread_d = 1'b0;
          tcnt_d  = '0;
        end
      end
      S_WAIT: begin
        tcnt_d = tcnt_inc;
        if (ufm_data_valid) begin
          if (!end_marker) begin
            led_d = ufm_data[7:0];
            dur_d = ufm_data[15:8];
            pre_d = '0;
          end
        end else if (timeout_hit) begin
          error_d = 1'b1;
        end
      end
      S_SHOW: begin
        pre_d = tick ? '0 : pre + 1'b1;
        if (tick) dur_d = dur - 8'd1;
        if (last_tick && !last_step) begin
          step_d = step + 1'b1;
          addr_d = ufm_addr + 1'b1;
        end
      end
      S_DONE: begin
        done_d    = 1'b1;
        running_d = 1'b0;
        led_d     = 8'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ufm_led_sequencer.sv
// tb/tb_ufm_led_sequencer.sv - directed self-checking bench for ufm_led_sequencer
module tb_ufm_led_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, ufm_busy, ufm_data_valid;
  logic [15:0] ufm_data;
  logic [8:0]  ufm_addr;
  logic        ufm_nread;
  logic [7:0]  led;
  logic        running, done, error;

  always #5 clk = ~clk;

  ufm_led_sequencer #(
    .ADDR_W(9), .BASE_ADDR(0), .N_STEPS(3), .TICK_DIV(4), .TIMEOUT(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ufm_addr(ufm_addr), .ufm_nread(ufm_nread), .ufm_busy(ufm_busy),
    .ufm_data_valid(ufm_data_valid), .ufm_data(ufm_data),
    .led(led), .running(running), .done(done), .error(error)
  );

  int nchecks = 0;
  int nerrors = 0;

  // UFM model: data returned two cycles after the strobe cycle
  logic [15:0] mem [0:7];
  bit          no_valid = 1'b0;
  int          pend = 0;
  logic [8:0]  paddr = 9'd0;

  always @(negedge clk) begin
    ufm_data_valid = 1'b0;
    if (pend == 1) begin
      ufm_data_valid = 1'b1;
      ufm_data = mem[paddr[2:0]];
    end
    if (pend > 0) pend = pend - 1;
    if (ufm_nread === 1'b0 && !no_valid) begin
      pend  = 2;
      paddr = ufm_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         n_strobe, c_led1, c_led2, done_cyc, done_cnt, run_low;
  logic [8:0] s_addr [0:7];
  int         s_cyc [0:7];
  logic [7:0] led_done, rs_led, late_led;
  logic       err_done, err_c1, run_done;
  logic       rs_run, rs_nread, rs_done, rs_err, late_run;
  logic [8:0] rs_addr;

  // Pulses start before edge 1 and records events by edge index
  task automatic run(input logic [7:0] p1, input logic [7:0] p2, input int busy_until,
                     input int rst_at, input int kick_at, input int maxc);
    n_strobe = 0; c_led1 = -1; c_led2 = -1; done_cyc = -1; done_cnt = 0; run_low = 0;
    for (int i = 0; i < 8; i++) begin
      s_addr[i] = 9'h1ff;
      s_cyc[i]  = -1;
    end
    ufm_busy = (busy_until > 0);
    start = 1'b1;
    for (int c = 1; c <= maxc; c++) begin
      tick();
      start = 1'b0;
      if (c == 1) err_c1 = error;
      if (!ufm_nread) begin
        if (n_strobe < 8) begin
          s_addr[n_strobe] = ufm_addr;
          s_cyc[n_strobe]  = c;
        end
        n_strobe++;
      end
      if (led == p1 && c_led1 < 0) c_led1 = c;
      if (led == p2 && c_led2 < 0) c_led2 = c;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          led_done = led;
          err_done = error;
          run_done = running;
        end
      end
      if (done_cyc < 0 && !running) run_low++;
      if (c == busy_until) ufm_busy = 1'b0;
      if (c == kick_at) start = 1'b1;
      if (rst_at > 0 && c == rst_at) rst = 1'b1;
      if (rst_at > 0 && c == rst_at + 1) begin
        rst = 1'b0;
        rs_led = led; rs_run = running; rs_nread = ufm_nread;
        rs_done = done; rs_err = error; rs_addr = ufm_addr;
      end
      if (rst_at > 0 && c == rst_at + 3) begin
        late_led = led;
        late_run = running;
        break;
      end
      if (done_cyc > 0 && c == done_cyc + 2) break;
    end
    ufm_busy = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic load_seq_a();
    mem[0] = 16'h0255; mem[1] = 16'h01AA; mem[2] = 16'h0000; mem[3] = 16'h0177;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ufm_busy = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    load_seq_a();
    tick(); tick();
    check("rst_led", led, 8'h00);
    check("rst_nread", ufm_nread, 1'b1);
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_addr", ufm_addr, 9'd0);
    rst = 1'b0;
    tick();

    // two-step sequence ending on a zero-duration word
    run(8'h55, 8'hAA, 0, 0, 0, 60);
    check("t1_nstrobe", n_strobe, 3);
    check("t1_addr0", s_addr[0], 9'd0);
    check("t1_addr1", s_addr[1], 9'd1);
    check("t1_addr2", s_addr[2], 9'd2);
    check("t1_cyc0", s_cyc[0], 2);
    check("t1_cyc1", s_cyc[1], 14);
    check("t1_cyc2", s_cyc[2], 22);
    check("t1_led55", c_led1, 5);
    check("t1_ledAA", c_led2, 17);
    check("t1_done_cyc", done_cyc, 26);
    check("t1_done_width", done_cnt, 1);
    check("t1_led_done", led_done, 8'h00);
    check("t1_run_done", run_done, 1'b0);
    check("t1_run_low", run_low, 0);

    // busy held for the first request
    run(8'h55, 8'hAA, 5, 0, 0, 60);
    check("t2_nstrobe", n_strobe, 3);
    check("t2_cyc0", s_cyc[0], 6);
    check("t2_cyc1", s_cyc[1], 18);
    check("t2_cyc2", s_cyc[2], 26);
    check("t2_done_cyc", done_cyc, 30);

    // read timeout
    no_valid = 1'b1;
    run(8'h55, 8'hAA, 0, 0, 0, 60);
    check("t3_nstrobe", n_strobe, 1);
    check("t3_cyc0", s_cyc[0], 2);
    check("t3_done_cyc", done_cyc, 13);
    check("t3_err_done", err_done, 1'b1);
    check("t3_led_done", led_done, 8'h00);
    check("t3_err_sticky", error, 1'b1);
    no_valid = 1'b0;

    // step limit: four nonzero words, only three played
    mem[0] = 16'h0111; mem[1] = 16'h0122; mem[2] = 16'h0133; mem[3] = 16'h0144;
    run(8'h11, 8'h33, 0, 0, 0, 60);
    check("t4_err_cleared", err_c1, 1'b0);
    check("t4_nstrobe", n_strobe, 3);
    check("t4_addr2", s_addr[2], 9'd2);
    check("t4_cyc2", s_cyc[2], 18);
    check("t4_led11", c_led1, 5);
    check("t4_led33", c_led2, 21);
    check("t4_done_cyc", done_cyc, 26);
    check("t4_err_done", err_done, 1'b0);

    // reset during SHOW
    load_seq_a();
    run(8'h55, 8'hAA, 0, 8, 0, 60);
    check("t5_led", rs_led, 8'h00);
    check("t5_run", rs_run, 1'b0);
    check("t5_nread", rs_nread, 1'b1);
    check("t5_done", rs_done, 1'b0);
    check("t5_err", rs_err, 1'b0);
    check("t5_addr", rs_addr, 9'd0);

    // reset during WAIT, data arrives the cycle after
    run(8'h55, 8'hAA, 0, 3, 0, 20);
    check("t6_led", rs_led, 8'h00);
    check("t6_run", rs_run, 1'b0);
    check("t6_nread", rs_nread, 1'b1);
    check("t6_late_led", late_led, 8'h00);
    check("t6_late_run", late_run, 1'b0);

    // start pulsed during SHOW is ignored; playback restarts from base
    run(8'h55, 8'hAA, 0, 0, 7, 60);
    check("t7_nstrobe", n_strobe, 3);
    check("t7_addr0", s_addr[0], 9'd0);
    check("t7_addr1", s_addr[1], 9'd1);
    check("t7_addr2", s_addr[2], 9'd2);
    check("t7_cyc1", s_cyc[1], 14);
    check("t7_done_cyc", done_cyc, 26);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
